pparch_addsub16_pipe: RTL and testbench
=======================================

PPARCH_ADDSUB16_PIPE -- requirements
Module: pparch_addsub16_pipe

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block accepts beat this cycle.
REQ-006 a  input  16  operand A, two's complement or unsigned.
REQ-007 b  input  16  operand B.
REQ-008 op  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 res  output  16  sum/difference.
REQ-012 co  output  1  add: carry-out; sub: borrow (= NOT carry-out).
REQ-013 ovf  output  1  signed overflow.
REQ-014 zero  output  1  res == 16'h0000.

Function
REQ-015 Beat transfers in when in_valid & in_ready; out when out_valid & out_ready.
REQ-016 Pre-compute: bb = op ? ~b : b; cin = op; p = a ^ bb; g = a & bb; cin enters as g at position 0 (carry into bit 0).
REQ-017 Carry network SHALL be a 16-bit sparse parallel-prefix tree (black/grey cells, span-2 stage then spans 4, 8, 16, final grey fill for even bits); ripple-carry forbidden.
REQ-018 Stage 1 (S1) SHALL register p, g, op and the span-1 and span-2 group G/P outputs; stage 2 (S2) SHALL complete remaining prefix levels, form res = p ^ c, flags, and register them.
REQ-019 Latency: 2 cycles from input accept to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-020 ovf = carry into bit 15 XOR carry out of bit 15.
REQ-021 S2 load enable: s2_en = !out_valid | out_ready.
REQ-022 S1 advances into S2 when s2_en; s1_valid propagates to out_valid on s2_en.
REQ-023 in_ready = !s1_valid | s2_en (combinational, no dependence on in_valid).
REQ-024 When out_valid & !out_ready, res/co/ovf/zero SHALL hold stable; no beat lost or duplicated.
REQ-025 Simultaneous output drain and input accept in a full pipe SHALL advance both stages same cycle.
REQ-026 Bubble (in_valid low while S1 drains) SHALL clear s1_valid; data registers may hold stale values but out_valid gates them.
REQ-027 Beat order preserved; no reordering.

Reset
REQ-028 rst high SHALL immediately clear s1_valid and out_valid; res, co, ovf, zero SHALL reset to 0 (zero reset value 0, not 1).
REQ-029 rst asserted mid-operation SHALL discard all in-flight beats; in_ready = 1 during and after reset.
REQ-030 First beat after rst release SHALL emerge exactly 2 cycles after acceptance.

Verification
REQ-031 op=1, a=0x0005, b=0x0003 -> res=0x0002, co=0, ovf=0, zero=0, out_valid 2 cycles after accept.
REQ-032 op=1, a=0x0000, b=0x0001 -> res=0xFFFF, co=1, ovf=0; op=1, a=0x8000, b=0x0001 -> res=0x7FFF, co=0, ovf=1.
REQ-033 op=0, a=0x7FFF, b=0x0001 -> res=0x8000, co=0, ovf=1; op=0, a=0xFFFF, b=0x0001 -> res=0x0000, co=1, zero=1.
REQ-034 Back-to-back 8 beats with out_ready held low from cycle 3 for 4 cycles -> in_ready falls once both stages full, outputs stable while stalled, all 8 results delivered in order.
REQ-035 Assert rst with 2 beats in flight -> out_valid=0 same cycle, neither beat appears after release.
REQ-036 Random 10k beats, random in_valid/out_ready, both ops -> every res/co/ovf matches 17-bit reference model, count in = count out.

Source files
------------

// File: rtl/pparch_addsub16_pipe_if.sv
// Operand/result handshake bundle for the 16-bit add/sub pipeline.
// The master drives operands and consumes results; the slave is the pipeline.
interface pparch_addsub16_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic        co;
  logic        ovf;
  logic        zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, res, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, res, co, ovf, zero
  );
endinterface

// File: rtl/pparch_addsub16_pipe.sv
// 16-bit add/sub on a sparse parallel-prefix carry tree, 2-cycle latency, 1 beat/cycle.
// A stalled output freezes S2; S1 still accepts while empty, so in_ready drops only when both stages are full.
module pparch_addsub16_pipe (
  input  logic                        clk,
  input  logic                        rst,
  pparch_addsub16_pipe_if.slave       bus
);

  logic        s2_en;
  logic        in_ready;
  logic        s1_valid;
  logic        s1_op;
  logic [15:0] s1_p;
  logic [8:1]  s1_ge;
  logic [7:0]  s1_g2;
  logic [7:1]  s1_p2;
  logic        out_valid;
  logic [15:0] res;
  logic        co;
  logic        ovf;
  logic        zero;

  // Carry-in sits below bit 0 as a generate, so pair k spans bits 2k and 2k-1.
  logic [15:0] bb, p, g;
  logic [7:0]  g2;
  logic [7:1]  p2;
  logic [8:1]  ge;

  always_comb begin
    bb    = bus.op ? ~bus.b : bus.b;
    p     = bus.a ^ bb;
    g     = bus.a & bb;
    g2[0] = g[0] | (p[0] & bus.op);
    for (int k = 1; k < 8; k++) begin
      g2[k] = g[2*k] | (p[2*k] & g[2*k-1]);
      p2[k] = p[2*k] & p[2*k-1];
    end
    for (int m = 1; m < 9; m++) begin
      ge[m] = g[2*m-1];
    end
  end

  // Odd-position tree at spans 4/8/16, then grey cells fill the even positions.
  logic [7:0]  g1, gl2, g3;
  logic [7:2]  p1;
  logic [7:4]  pl2;
  logic [16:0] c;
  logic [15:0] sum;

  always_comb begin
    g1[0] = s1_g2[0];
    for (int k = 1; k < 8; k++) g1[k] = s1_g2[k] | (s1_p2[k] & s1_g2[k-1]);
    for (int k = 2; k < 8; k++) p1[k] = s1_p2[k] & s1_p2[k-1];

    gl2[1:0] = g1[1:0];
    for (int k = 2; k < 8; k++) gl2[k] = g1[k] | (p1[k] & g1[k-2]);
    for (int k = 4; k < 8; k++) pl2[k] = p1[k] & p1[k-2];

    g3[3:0] = gl2[3:0];
    for (int k = 4; k < 8; k++) g3[k] = gl2[k] | (pl2[k] & gl2[k-4]);

    c[0] = s1_op;
    for (int k = 0; k < 8; k++) c[2*k+1] = g3[k];
    for (int m = 1; m < 9; m++) c[2*m] = s1_ge[m] | (s1_p[2*m-1] & g3[m-1]);

    sum = s1_p ^ c[15:0];
  end

  assign s2_en    = !out_valid | bus.out_ready;
  assign in_ready = !s1_valid | s2_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= 1'b0;
      s1_p     <= '0;
      s1_ge    <= '0;
      s1_g2    <= '0;
      s1_p2    <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op <= bus.op;
        s1_p  <= p;
        s1_ge <= ge;
        s1_g2 <= g2;
        s1_p2 <= p2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res  <= sum;
        co   <= c[16] ^ s1_op;
        ovf  <= c[15] ^ c[16];
        zero <= (sum == 16'h0000);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.res       = res;
  assign bus.co        = co;
  assign bus.ovf       = ovf;
  assign bus.zero      = zero;

endmodule

// File: tb/tb_pparch_addsub16_pipe.sv
// Bench for pparch_addsub16_pipe: directed vectors, stall, mid-flight reset and random traffic
// against a 17-bit arithmetic reference model with an in-order expectation queue.
module tb_pparch_addsub16_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pparch_addsub16_pipe_if bus ();

  pparch_addsub16_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ovf;
    logic        zero;
  } rslt_t;

  rslt_t expq[$];
  int    tests = 0;
  int    fails = 0;
  int    n_in  = 0;
  int    n_out = 0;
  rslt_t held;
  bit    stalled = 1'b0;

  function automatic rslt_t model(logic op, logic [15:0] a, logic [15:0] b);
    rslt_t       r;
    logic [16:0] s;
    if (!op) begin
      s     = {1'b0, a} + {1'b0, b};
      r.co  = s[16];
      r.ovf = (a[15] == b[15]) && (s[15] != a[15]);
    end else begin
      s     = {1'b0, a} - {1'b0, b};
      r.co  = (a < b);
      r.ovf = (a[15] != b[15]) && (s[15] != a[15]);
    end
    r.res  = s[15:0];
    r.zero = (s[15:0] == 16'h0000);
    return r;
  endfunction

  function automatic rslt_t cur();
    return {bus.res, bus.co, bus.ovf, bus.zero};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every handshake seen mid-cycle is the one the next rising edge commits.
  always @(negedge clk) begin
    rslt_t e;
    if (rst) begin
      expq.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_hold_valid", 32'(bus.out_valid), 1);
        chk("stall_hold_data", 32'(cur()), 32'(held));
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.op, bus.a, bus.b));
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_beat: got res=%0h with no beat expected", bus.res);
        end else begin
          e = expq.pop_front();
          chk("result", 32'(cur()), 32'(e));
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = cur();
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(string name, logic op, logic [15:0] a, logic [15:0] b, rslt_t want);
    chk({name, "_model"}, 32'(model(op, a, b)), 32'(want));
    next_cycle();
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, 32'(bus.in_ready), 1);
    next_cycle();
    bus.in_valid = 1'b0;
    chk({name, "_not_early"}, 32'(bus.out_valid), 0);
    next_cycle();
    chk({name, "_latency"}, 32'(bus.out_valid), 1);
    chk({name, "_dut"}, 32'(cur()), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  sent;
  int  cyc;
  bit  fell;

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) next_cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_outputs", 32'(cur()), 0);
    rst = 1'b0;

    directed("sub_5_3",      1'b1, 16'h0005, 16'h0003, {16'h0002, 1'b0, 1'b0, 1'b0});
    directed("sub_0_1",      1'b1, 16'h0000, 16'h0001, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    directed("sub_8000_1",   1'b1, 16'h8000, 16'h0001, {16'h7FFF, 1'b0, 1'b1, 1'b0});
    directed("add_7fff_1",   1'b0, 16'h7FFF, 16'h0001, {16'h8000, 1'b0, 1'b1, 1'b0});
    directed("add_ffff_1",   1'b0, 16'hFFFF, 16'h0001, {16'h0000, 1'b1, 1'b0, 1'b1});
    directed("add_1234_edcc",1'b0, 16'h1234, 16'hEDCC, {16'h0000, 1'b1, 1'b0, 1'b1});

    // Back-to-back 8 beats with a 4-cycle output stall starting at cycle 3.
    next_cycle();
    sent = 0;
    cyc  = 0;
    fell = 1'b0;
    bus.a  = 16'($urandom);
    bus.b  = 16'($urandom);
    bus.op = 1'($urandom);
    while (sent < 8 && cyc < 40) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = !(cyc >= 3 && cyc < 7);
      #2;
      if (!bus.in_ready) fell = 1'b1;
      else sent++;
      next_cycle();
      if (bus.in_valid && sent > 0) begin
        bus.a  = 16'($urandom);
        bus.b  = 16'($urandom);
        bus.op = 1'($urandom);
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("b2b_sent", 32'(sent), 8);
    chk("b2b_in_ready_fell", 32'(fell), 1);
    repeat (6) next_cycle();
    chk("b2b_drained", 32'(expq.size()), 0);

    // Two beats in flight, then reset.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.op = 1'b0;
    next_cycle();
    bus.a = 16'h3333; bus.b = 16'h0001; bus.op = 1'b1;
    next_cycle();
    bus.in_valid = 1'b0;
    chk("flight_out_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_kill_valid", 32'(bus.out_valid), 0);
    chk("rst_kill_in_ready", 32'(bus.in_ready), 1);
    repeat (2) next_cycle();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      chk("post_rst_no_beat", 32'(bus.out_valid), 0);
    end

    // Random traffic.
    n_in  = 0;
    n_out = 0;
    cyc   = 0;
    while (n_in < 10000 && cyc < 60000) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.a         = 16'($urandom);
      bus.b         = 16'($urandom);
      bus.op        = 1'($urandom);
      bus.out_ready = ($urandom_range(9) < 7);
      next_cycle();
      cyc++;
    end
    chk("rand_budget", 32'(n_in >= 10000), 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) next_cycle();
    chk("rand_count_in_out", 32'(n_out), 32'(n_in));
    chk("rand_queue_empty", 32'(expq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
